// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_controller
// Description : Two-line external interrupt front end. Synchronizes the lines,
//               detects rising edges, keeps per-line pending flags and hands
//               one prioritized request at a time to the exception controller.
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_controller #(
  parameter int SYNC_STAGES = 2   // legal range 2..4
) (
  input  logic       Clock,
  input  logic       SysReset,
  input  logic [1:0] IRQ_Ext,
  input  logic [1:0] IntMask,
  input  logic       IntAck,
  output logic       IRQ_Int,
  output logic       IID_Sync,
  output logic [1:0] Pending
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_stateNext;
  logic [1:0] w_syncOut;
  logic [1:0] r_prev;
  logic [1:0] w_rise;
  logic [1:0] r_pend;
  logic [1:0] w_clrMask;
  logic [1:0] w_pendNext;
  logic       w_ackTaken;
  logic       r_irq;
  logic       w_irqNext;
  logic       r_id;
  logic       w_idNext;

  // Per-line synchronizer chain; the last stage is the synchronized level.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] r_chain;

      // Shift the raw line into the chain every cycle.
      always_ff @(posedge Clock or negedge SysReset) begin
        if (!SysReset) begin
          r_chain <= '0;
        end else begin
          r_chain <= {r_chain[SYNC_STAGES-2:0], IRQ_Ext[gi]};
        end
      end

      assign w_syncOut[gi] = r_chain[SYNC_STAGES-1];
    end
  endgenerate

  // Remember the previous synchronized level for edge detection.
  always_ff @(posedge Clock or negedge SysReset) begin
    if (!SysReset) begin
      r_prev <= 2'b00;
    end else begin
      r_prev <= w_syncOut;
    end
  end

  assign w_rise = w_syncOut & ~r_prev;

  // An ack only counts while a request is actually presented.
  assign w_ackTaken = IntAck && (r_state == ST_REQ);
  assign w_clrMask  = w_ackTaken ? (r_id ? 2'b10 : 2'b01) : 2'b00;
  // Set is applied after clear so a coincident rise keeps the bit pending.
  assign w_pendNext = (r_pend & ~w_clrMask) | (w_rise & IntMask);

  // Pending flags: masked rises set, accepted acks clear the serviced line.
  always_ff @(posedge Clock or negedge SysReset) begin
    if (!SysReset) begin
      r_pend <= 2'b00;
    end else begin
      r_pend <= w_pendNext;
    end
  end

  // Request sequencing: IDLE picks the highest pending line, REQ holds the
  // frozen ID until ack, GAP blanks the request for one cycle.
  always_comb begin
    w_stateNext = r_state;
    w_idNext    = r_id;
    case (r_state)
      ST_IDLE: begin
        if (r_pend != 2'b00) begin
          w_stateNext = ST_REQ;
          w_idNext    = r_pend[1];
        end
      end
      ST_REQ: begin
        if (IntAck) begin
          w_stateNext = ST_GAP;
        end
      end
      ST_GAP: begin
        w_stateNext = ST_IDLE;
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
    w_irqNext = (w_stateNext == ST_REQ);
  end

  // State register plus registered request and ID outputs.
  always_ff @(posedge Clock or negedge SysReset) begin
    if (!SysReset) begin
      r_state <= ST_IDLE;
      r_irq   <= 1'b0;
      r_id    <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_irq   <= w_irqNext;
      r_id    <= w_idNext;
    end
  end

  assign IRQ_Int  = r_irq;
  assign IID_Sync = r_id;
  assign Pending  = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_interrupt_controller
// Description : Randomized self-checking bench for interrupt_controller with a
//               cycle-level behavioural model of the request rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_controller;

  localparam int S = 2;

  logic       Clock;
  logic       SysReset;
  logic [1:0] IRQ_Ext;
  logic [1:0] IntMask;
  logic       IntAck;
  logic       IRQ_Int;
  logic       IID_Sync;
  logic [1:0] Pending;

  int errCnt = 0;
  int chkCnt = 0;

  // Model state: sample history, pending flags, presented request.
  logic [1:0] hq[$];
  logic [1:0] mPend;
  logic       mIrq;
  logic       mId;
  int         edgeN;
  int         earliest;

  interrupt_controller #(.SYNC_STAGES(S)) dut (
    .Clock    (Clock),
    .SysReset (SysReset),
    .IRQ_Ext  (IRQ_Ext),
    .IntMask  (IntMask),
    .IntAck   (IntAck),
    .IRQ_Int  (IRQ_Int),
    .IID_Sync (IID_Sync),
    .Pending  (Pending)
  );

  // Free-running core clock.
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    hq.delete();
    for (int i = 0; i <= S; i++) hq.push_back(2'b00);
    mPend    = 2'b00;
    mIrq     = 1'b0;
    mId      = 1'b0;
    edgeN    = 0;
    earliest = 0;
  endtask

  // One rising edge of the reference: a rise on a line is the level sampled
  // S edges ago being high while the one before it was low.
  task automatic modelStep();
    logic [1:0] rise;
    logic [1:0] oldPend;
    logic [1:0] clr;
    rise    = hq[S-1] & ~hq[S];
    hq.push_front(IRQ_Ext);
    void'(hq.pop_back());
    oldPend = mPend;
    clr     = 2'b00;
    if (mIrq && IntAck) begin
      clr[mId] = 1'b1;
      mIrq     = 1'b0;
      earliest = edgeN + 2;
    end else if (!mIrq && edgeN >= earliest && oldPend != 2'b00) begin
      mIrq = 1'b1;
      mId  = oldPend[1];
    end
    mPend = (oldPend & ~clr) | (rise & IntMask);
    edgeN++;
  endtask

  task automatic compareOutputs();
    check("irq", 32'(IRQ_Int), 32'(mIrq));
    check("pending", 32'(Pending), 32'(mPend));
    if (mIrq) check("iid", 32'(IID_Sync), 32'(mId));
  endtask

  // One clock: model follows the edge, outputs checked at the falling edge,
  // then fresh stimulus is applied for the next edge.
  task automatic runCycle(input int togOdds, input int ackOdds);
    @(posedge Clock);
    modelStep();
    @(negedge Clock);
    compareOutputs();
    for (int b = 0; b < 2; b++) begin
      if ($urandom_range(0, togOdds - 1) == 0) IRQ_Ext[b] = ~IRQ_Ext[b];
    end
    IntAck = ($urandom_range(0, ackOdds - 1) == 0);
  endtask

  initial begin
    logic [1:0] masks [6];
    bit         seen;
    masks[0] = 2'b11; masks[1] = 2'b10; masks[2] = 2'b01;
    masks[3] = 2'b11; masks[4] = 2'b00; masks[5] = 2'b11;

    SysReset = 1'b0;
    IRQ_Ext  = 2'b00;
    IntMask  = 2'b11;
    IntAck   = 1'b0;
    modelReset();
    repeat (3) @(negedge Clock);
    check("rst_irq", 32'(IRQ_Int), 32'd0);
    check("rst_iid", 32'(IID_Sync), 32'd0);
    check("rst_pending", 32'(Pending), 32'd0);
    SysReset = 1'b1;

    for (int p = 0; p < 6; p++) begin
      IntMask = masks[p];
      for (int c = 0; c < 400; c++) begin
        runCycle((p % 2 == 0) ? 6 : 12, (p < 3) ? 3 : 5);
        if (c % 100 == 99) IntMask = 2'($urandom_range(0, 3));
      end

      if (p == 2) begin
        // Asynchronous reset while a request is presented.
        IntMask = 2'b11;
        IntAck  = 1'b0;
        IRQ_Ext = 2'b00;
        seen    = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
          if (c == 10) IRQ_Ext = 2'b11;
          runCycle(1000000, 1000000);
          IntAck = 1'b0;
          seen   = mIrq;
        end
        check("reset_wait_irq", 32'(seen), 32'd1);
        #1;
        SysReset = 1'b0;
        #1;
        check("async_rst_irq", 32'(IRQ_Int), 32'd0);
        check("async_rst_iid", 32'(IID_Sync), 32'd0);
        check("async_rst_pending", 32'(Pending), 32'd0);
        modelReset();
        repeat (2) @(negedge Clock);
        // Lines stay high across release: each must be seen as a fresh rise.
        SysReset = 1'b1;
        for (int c = 0; c < 20; c++) begin
          runCycle(1000000, 4);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
`default_nettype wire
